// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO; even parity added when UART_RX_PARITY_EN is defined.
// Latency: 2 clks from the stop-bit sample to data_valid; the FIFO does not fall through.
// Backpressure: rx cannot be stalled; a full FIFO without a same-cycle pop drops the byte and pulses overrun.

// uart_rx_fifo_buf: power-of-two FIFO with a registered head word.
// Latency: a push is visible at the head one clk after its write edge.
// Backpressure: push is refused when full unless a pop lands in the same clk; pop while empty is ignored.
module uart_rx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             full
);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_vld && !empty;
  assign do_push = push_vld && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // The new head is the incoming byte only when the read pointer lands on the slot being written.
    if (do_push && (rd_ptr_d == wr_ptr_q)) begin
      head_d = push_dat;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_dat = head_q;
  assign count    = count_q;
endmodule

module uart_rx_fifo #(
  parameter int CLKS_PER_TICK = 326,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_STAGES   = 2,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic [7:0]    data_out,
  output logic          data_valid,
  input  logic          data_ready,
  output logic [CW-1:0] fifo_count,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy,
  output logic [2:0]    rx_state
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_CLEANUP = 3'd5;

  localparam int DW = $clog2(CLKS_PER_TICK + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_TICK - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   push_q, push_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_s, tick, fifo_full;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign tick   = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_ONE;
    end
    case (state_q)
      S_IDLE: begin
        div_d      = '0;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        par_err_d  = 1'b0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            state_d    = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          // 4-bit counter wraps 15 -> 0, aligning each following sample one bit period later.
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            par_err_d = ^{rx_s, shift_q};
            state_d   = S_STOP;
          end
        end
      end
`else
      S_PARITY: state_d = S_IDLE;
`endif
      S_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            state_d = S_CLEANUP;
            if (rx_s && !par_err_q) begin
              push_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
      end
      S_CLEANUP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign overrun_d = push_q && fifo_full && !(data_valid && data_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '1;
      state_q     <= S_IDLE;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo_buf #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_q),
    .push_dat (shift_q),
    .pop_vld  (data_ready),
    .head_dat (data_out),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  assign data_valid = (fifo_count != '0);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
  assign rx_state   = state_q;
endmodule
